seven_seg_mux_sj: RTL and testbench



---
 rtl/seven_seg_mux_sj.sv | 132 +++++++++++++
 tb/tb_seven_seg_mux_sj.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/seven_seg_mux_sj.sv
// Time-multiplexed hex driver for NUM_DIGITS common-anode digits on a shared active-low segment bus.
// Optional macro LEADING_ZERO_BLANK_EN suppresses leading-zero digits (digit 0 is always shown).
module seven_seg_mux_sj #(
    parameter int NUM_DIGITS   = 2,
    parameter int REFRESH_DIV  = 24000,
    parameter int BLANK_CYCLES = 16
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic [4*NUM_DIGITS-1:0] digits_in,
    input  logic                    load,
    output logic [6:0]              seg,
    output logic [NUM_DIGITS-1:0]   an,
    output logic                    frame_start
);

    localparam int MAX_DWELL  = (REFRESH_DIV > BLANK_CYCLES) ? REFRESH_DIV : BLANK_CYCLES;
    localparam int CNT_W      = $clog2(MAX_DWELL + 1);
    localparam int IDX_W      = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int BLANK_LAST = (BLANK_CYCLES > 0) ? BLANK_CYCLES - 1 : 0;

    typedef enum logic {SHOW, BLANK} state_t;

    state_t                  state, state_nxt;
    logic [IDX_W-1:0]        idx, idx_nxt;
    logic [CNT_W-1:0]        cnt, cnt_nxt;
    logic [4*NUM_DIGITS-1:0] active, pending, active_p0;
    logic                    pend_flag;
    logic                    boundary_p0;
    logic                    show_en_p0;
    logic [3:0]              nib_p0;
    logic [6:0]              seg_p0;
    logic [NUM_DIGITS-1:0]   an_p0;

    function automatic logic [6:0] decode(input logic [3:0] v);
        case (v)
            4'h0: return 7'h40;
            4'h1: return 7'h79;
            4'h2: return 7'h24;
            4'h3: return 7'h30;
            4'h4: return 7'h19;
            4'h5: return 7'h12;
            4'h6: return 7'h02;
            4'h7: return 7'h78;
            4'h8: return 7'h00;
            4'h9: return 7'h18;
            4'hA: return 7'h08;
            4'hB: return 7'h03;
            4'hC: return 7'h46;
            4'hD: return 7'h21;
            4'hE: return 7'h06;
            default: return 7'h0E;
        endcase
    endfunction

    function automatic logic [IDX_W-1:0] idx_inc(input logic [IDX_W-1:0] i);
        if (i == IDX_W'(NUM_DIGITS - 1)) return '0;
        else return i + IDX_W'(1);
    endfunction

    // Stage p0: frame boundary, buffer swap view, next state and next outputs
    always_comb begin
        boundary_p0 = (state == SHOW) && (idx == '0) && (cnt == '0);
        // The swap is visible in the boundary cycle itself so the new frame starts on new data
        active_p0   = (boundary_p0 && pend_flag) ? pending : active;

        nib_p0     = active_p0[3:0];
        show_en_p0 = 1'b1;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (idx == IDX_W'(i)) begin
                nib_p0 = active_p0[4*i +: 4];
`ifdef LEADING_ZERO_BLANK_EN
                if (i != 0 && (active_p0 >> (4*i)) == '0) show_en_p0 = 1'b0;
`endif
            end
        end

        state_nxt = state;
        idx_nxt   = idx;
        cnt_nxt   = cnt + CNT_W'(1);
        case (state)
            SHOW: begin
                if (cnt == CNT_W'(REFRESH_DIV - 1)) begin
                    cnt_nxt = '0;
                    if (BLANK_CYCLES == 0) idx_nxt = idx_inc(idx);
                    else                   state_nxt = BLANK;
                end
            end
            default: begin
                if (cnt == CNT_W'(BLANK_LAST)) begin
                    cnt_nxt   = '0;
                    idx_nxt   = idx_inc(idx);
                    state_nxt = SHOW;
                end
            end
        endcase

        seg_p0 = 7'h7F;
        an_p0  = '1;
        if (state == SHOW && show_en_p0) begin
            seg_p0 = decode(nib_p0);
            an_p0  = ~(NUM_DIGITS'(1) << idx);
        end
    end

    // Stage p1: registered scan state, buffers and pin outputs
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= SHOW;
            idx         <= '0;
            cnt         <= '0;
            active      <= '0;
            pending     <= '0;
            pend_flag   <= 1'b0;
            seg         <= 7'h7F;
            an          <= '1;
            frame_start <= 1'b0;
        end else begin
            state       <= state_nxt;
            idx         <= idx_nxt;
            cnt         <= cnt_nxt;
            active      <= active_p0;
            if (load) pending <= digits_in;
            // A load in the boundary cycle keeps the flag set for the next frame
            pend_flag   <= load ? 1'b1 : (boundary_p0 ? 1'b0 : pend_flag);
            seg         <= seg_p0;
            an          <= an_p0;
            frame_start <= boundary_p0;
        end
    end

endmodule

// File: tb/tb_seven_seg_mux_sj.sv
// Directed table-driven bench for seven_seg_mux_sj with NUM_DIGITS=2, REFRESH_DIV=4, BLANK_CYCLES=1.
module tb_seven_seg_mux_sj;

    localparam int ND = 2;
    localparam int RD = 4;
    localparam int BC = 1;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          load = 1'b0;
    logic [7:0]    digits_in = '0;
    logic [6:0]    seg;
    logic [ND-1:0] an;
    logic          frame_start;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    typedef struct {
        int         cyc;
        logic       ld;
        logic [7:0] din;
        logic       chk;
        logic [1:0] an;
        logic [6:0] seg;
        logic       fs;
        string      name;
    } vec_t;

    vec_t vecs[$];

    always #5 clk = ~clk;

    seven_seg_mux_sj #(
        .NUM_DIGITS  (ND),
        .REFRESH_DIV (RD),
        .BLANK_CYCLES(BC)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .digits_in  (digits_in),
        .load       (load),
        .seg        (seg),
        .an         (an),
        .frame_start(frame_start)
    );

    function automatic vec_t chk_v(int c, string n, logic [1:0] a, logic [6:0] s, logic f);
        vec_t v;
        v.cyc = c; v.ld = 1'b0; v.din = '0; v.chk = 1'b1;
        v.an = a; v.seg = s; v.fs = f; v.name = n;
        return v;
    endfunction

    function automatic vec_t ld_v(int c, logic [7:0] d);
        vec_t v;
        v.cyc = c; v.ld = 1'b1; v.din = d; v.chk = 1'b0;
        v.an = '0; v.seg = '0; v.fs = 1'b0; v.name = "load";
        return v;
    endfunction

    task automatic check(input string n, input logic [1:0] a, input logic [6:0] s, input logic f);
        checks++;
        if (an !== a || seg !== s || frame_start !== f) begin
            failures++;
            $display("FAIL %s @cyc %0d: got an=%b seg=%h fs=%b, expected an=%b seg=%h fs=%b",
                     n, cyc, an, seg, frame_start, a, s, f);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        cyc++;
        load = 1'b0;
    endtask

    task automatic run_vecs();
        foreach (vecs[i]) begin
            while (cyc < vecs[i].cyc) tick();
            if (vecs[i].chk) check(vecs[i].name, vecs[i].an, vecs[i].seg, vecs[i].fs);
            if (vecs[i].ld) begin
                load      = 1'b1;
                digits_in = vecs[i].din;
            end
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation exceeded time limit at cyc %0d", cyc);
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Output cycle c shows internal cycle c-1; frame boundaries at internal 0,10,20,...
        vecs.push_back(chk_v(0,  "post_release_hold", 2'b11, 7'h7F, 1'b0));
        vecs.push_back(chk_v(1,  "first_digit0",      2'b10, 7'h40, 1'b1));
        vecs.push_back(chk_v(2,  "digit0_dwell",      2'b10, 7'h40, 1'b0));
        vecs.push_back(chk_v(4,  "digit0_last",       2'b10, 7'h40, 1'b0));
        vecs.push_back(chk_v(5,  "blank_after_d0",    2'b11, 7'h7F, 1'b0));
        vecs.push_back(chk_v(6,  "first_digit1",      2'b01, 7'h40, 1'b0));
        vecs.push_back(ld_v (7,  8'hA3));
        vecs.push_back(chk_v(9,  "digit1_unchanged",  2'b01, 7'h40, 1'b0));
        vecs.push_back(chk_v(10, "blank_after_d1",    2'b11, 7'h7F, 1'b0));
        vecs.push_back(chk_v(11, "a3_digit0",         2'b10, 7'h30, 1'b1));
        vecs.push_back(chk_v(16, "a3_digit1",         2'b01, 7'h08, 1'b0));
        vecs.push_back(ld_v (21, 8'h12));
        vecs.push_back(chk_v(22, "a3_held_d0",        2'b10, 7'h30, 1'b0));
        vecs.push_back(ld_v (25, 8'h5F));
        vecs.push_back(chk_v(27, "a3_held_d1",        2'b01, 7'h08, 1'b0));
        vecs.push_back(chk_v(31, "lastwins_d0",       2'b10, 7'h0E, 1'b1));
        vecs.push_back(ld_v (33, 8'h44));
        vecs.push_back(chk_v(36, "lastwins_d1",       2'b01, 7'h12, 1'b0));
        vecs.push_back(chk_v(40, "blank_pre_bound",   2'b11, 7'h7F, 1'b0));
        vecs.push_back(ld_v (40, 8'h77));
        vecs.push_back(chk_v(41, "bound_44_d0",       2'b10, 7'h19, 1'b1));
        vecs.push_back(chk_v(46, "bound_44_d1",       2'b01, 7'h19, 1'b0));
        vecs.push_back(chk_v(51, "next_77_d0",        2'b10, 7'h78, 1'b1));
        vecs.push_back(chk_v(56, "next_77_d1",        2'b01, 7'h78, 1'b0));

        reset_n = 1'b0;
        repeat (2) @(negedge clk);
        check("reset_state", 2'b11, 7'h7F, 1'b0);
        reset_n = 1'b1;
        cyc = 0;
        run_vecs();

        // Asynchronous reset in the middle of digit 1's SHOW slot
        tick();
        #2 reset_n = 1'b0;
        #1 check("async_reset", 2'b11, 7'h7F, 1'b0);
        @(negedge clk);
        reset_n = 1'b1;
        cyc = 0;
        tick();
        check("restart_digit0", 2'b10, 7'h40, 1'b1);
        tick();
        check("restart_no_fs", 2'b10, 7'h40, 1'b0);

        vecs.delete();
        vecs.push_back(ld_v (3,  8'h05));
        vecs.push_back(chk_v(11, "v05_d0",            2'b10, 7'h12, 1'b1));
        vecs.push_back(ld_v (12, 8'h00));
`ifdef LEADING_ZERO_BLANK_EN
        vecs.push_back(chk_v(16, "v05_d1_blanked",    2'b11, 7'h7F, 1'b0));
`else
        vecs.push_back(chk_v(16, "v05_d1_zero",       2'b01, 7'h40, 1'b0));
`endif
        vecs.push_back(chk_v(21, "v00_d0",            2'b10, 7'h40, 1'b1));
        vecs.push_back(ld_v (22, 8'h50));
`ifdef LEADING_ZERO_BLANK_EN
        vecs.push_back(chk_v(26, "v00_d1_blanked",    2'b11, 7'h7F, 1'b0));
`else
        vecs.push_back(chk_v(26, "v00_d1_zero",       2'b01, 7'h40, 1'b0));
`endif
        vecs.push_back(chk_v(31, "v50_d0",            2'b10, 7'h40, 1'b1));
        vecs.push_back(chk_v(36, "v50_d1",            2'b01, 7'h12, 1'b0));
        run_vecs();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
